// File: rtl/ide_pio_timing.sv
// ATA PIO strobe sequencer: turns a decoded 68020 IDE cycle into timed IDECS/IOR/IOW strobes.
// Latency (defaults, no IORDY wait): request sampled edge 0, IDECS low edge 1, strobe edges 3-8, ACK low from edge 10.
// Backpressure: IORDY low stretches the strobe (bounded by T_WAITMAX); ACK is held until AS20 returns high.
//
// Ports:
//   CLKCPU   in   CPU clock; all state changes on its rising edge
//   RESET    in   asynchronous, active-high; forces every output inactive at once
//   AS20     in   CPU address strobe, active low
//   RW20     in   1 = read, 0 = write (latched at cycle start)
//   IDE_SEL  in   IDE region decode, active low
//   A12      in   chip-select choice: 0 -> IDECS[0], 1 -> IDECS[1] (latched at cycle start)
//   IORDY    in   drive ready, low extends the strobe; double-flopped here
//   IDECS    out  drive chip selects, active low
//   IOR/IOW  out  read / write strobes, active low
//   DATA_LE  out  one-cycle high pulse during the final read strobe cycle
//   ACK      out  active-low cycle-complete indication for the DSACK logic
//   TIMEOUT  out  sticky flag: IORDY wait limit reached; cleared when the next cycle starts

module ide_pio_timing #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_ACTIVE  = 6,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_RECOVER = 3,
  parameter int unsigned T_WAITMAX = 15,
  parameter int unsigned CW        = 4
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       IDE_SEL,
  input  logic       A12,
  input  logic       IORDY,
  output logic [1:0] IDECS,
  output logic       IOR,
  output logic       IOW,
  output logic       DATA_LE,
  output logic       ACK,
  output logic       TIMEOUT
);

  // Zero-length setup/active/hold phases would let a strobe overlap a chip-select edge,
  // so they are stretched to one cycle. Recovery may legitimately be zero.
  localparam int unsigned TS_EFF = (T_SETUP  == 0) ? 1 : T_SETUP;
  localparam int unsigned TA_EFF = (T_ACTIVE == 0) ? 1 : T_ACTIVE;
  localparam int unsigned TH_EFF = (T_HOLD   == 0) ? 1 : T_HOLD;

  // Each phase counter runs 0 .. LAST, so a phase lasts LAST+1 cycles.
  localparam logic [CW-1:0] SETUP_LAST   = CW'(TS_EFF - 1);
  localparam logic [CW-1:0] ACTIVE_LAST  = CW'(TA_EFF - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(TH_EFF - 1);
  localparam logic [CW-1:0] RECOVER_LAST = CW'((T_RECOVER == 0) ? 0 : T_RECOVER - 1);
  localparam logic [CW-1:0] WAIT_MAX     = CW'(T_WAITMAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK,
    ST_RECOVER
  } state_t;

  // Where a finished or abandoned cycle goes: straight back to IDLE when no recovery is wanted.
  localparam state_t AFTER_CYCLE = (T_RECOVER == 0) ? ST_IDLE : ST_RECOVER;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;          // phase length counter
  logic [CW-1:0] wait_cnt, wait_nxt;    // extra strobe cycles spent waiting for IORDY
  logic          cyc_rw, rw_nxt;        // direction of the cycle in flight
  logic          cyc_a12, a12_nxt;      // chip select of the cycle in flight
  logic          aborted, abort_nxt;    // AS20 withdrawn before completion: skip ACK
  logic          timeout_nxt;

  // IORDY synchroniser
  logic iordy_meta;
  logic iordy_sync;

  // Request sample register: the cycle start is decided one edge after the request is
  // seen, which also gives the latched RW/A12 a full cycle to settle.
  logic req_q;
  logic rw_q;
  logic a12_q;

  // Next values of the registered outputs
  logic [1:0] idecs_nxt;
  logic       ior_nxt;
  logic       iow_nxt;
  logic       data_le_nxt;
  logic       ack_nxt;
  logic       cs_on;
  logic       stb_on;

  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      iordy_meta <= 1'b1;
      iordy_sync <= 1'b1;
      req_q      <= 1'b0;
      rw_q       <= 1'b1;
      a12_q      <= 1'b0;
    end else begin
      iordy_meta <= IORDY;
      iordy_sync <= iordy_meta;
      req_q      <= ~AS20 & ~IDE_SEL;
      rw_q       <= RW20;
      a12_q      <= A12;
    end
  end

  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      cyc_rw   <= 1'b1;
      cyc_a12  <= 1'b0;
      aborted  <= 1'b0;
      TIMEOUT  <= 1'b0;
      IDECS    <= 2'b11;
      IOR      <= 1'b1;
      IOW      <= 1'b1;
      DATA_LE  <= 1'b0;
      ACK      <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      cyc_rw   <= rw_nxt;
      cyc_a12  <= a12_nxt;
      aborted  <= abort_nxt;
      TIMEOUT  <= timeout_nxt;
      IDECS    <= idecs_nxt;
      IOR      <= ior_nxt;
      IOW      <= iow_nxt;
      DATA_LE  <= data_le_nxt;
      ACK      <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wait_nxt    = wait_cnt;
    rw_nxt      = cyc_rw;
    a12_nxt     = cyc_a12;
    abort_nxt   = aborted;
    timeout_nxt = TIMEOUT;

    case (state)
      ST_IDLE: begin
        if (req_q) begin
          state_nxt   = ST_SETUP;
          cnt_nxt     = '0;
          wait_nxt    = '0;
          rw_nxt      = rw_q;
          a12_nxt     = a12_q;
          abort_nxt   = 1'b0;
          timeout_nxt = 1'b0;
        end
      end

      ST_SETUP: begin
        if (AS20) begin
          // No strobe issued yet: drop the chip select and recover.
          state_nxt = AFTER_CYCLE;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt >= SETUP_LAST) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = '0;
          wait_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_STROBE: begin
        if (AS20) begin
          // Strobe released on this edge; chip select still gets its hold time.
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt < ACTIVE_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (iordy_sync) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else if (wait_cnt >= WAIT_MAX) begin
          state_nxt   = ST_HOLD;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt >= HOLD_LAST) begin
          state_nxt = aborted ? AFTER_CYCLE : ST_ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_ACK: begin
        if (AS20) begin
          state_nxt = AFTER_CYCLE;
          cnt_nxt   = '0;
        end
      end

      ST_RECOVER: begin
        if (cnt >= RECOVER_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        wait_nxt  = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    cs_on  = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);
    stb_on = (state_nxt == ST_STROBE);

    idecs_nxt = 2'b11;
    if (cs_on) begin
      idecs_nxt = a12_nxt ? 2'b01 : 2'b10;
    end

    ior_nxt = ~(stb_on & rw_nxt);
    iow_nxt = ~(stb_on & ~rw_nxt);
    ack_nxt = ~(state_nxt == ST_ACK);

    // DATA_LE must be high during the final strobe cycle, which is only decided at that
    // cycle's closing edge. The value the FSM will see there is what sits in iordy_meta
    // now, so the last cycle can be identified one edge early. A withdrawal of AS20
    // landing exactly on that closing edge cannot be foreseen; the data is valid anyway.
    data_le_nxt = stb_on & rw_nxt & (cnt_nxt >= ACTIVE_LAST)
                & (iordy_meta | (wait_nxt >= WAIT_MAX));
  end

endmodule

// File: tb/tb_ide_pio_timing.sv
module tb_ide_pio_timing;

  logic       CLKCPU  = 1'b0;
  logic       RESET   = 1'b1;
  logic       AS20    = 1'b1;
  logic       RW20    = 1'b1;
  logic       IDE_SEL = 1'b1;
  logic       A12     = 1'b0;
  logic       IORDY   = 1'b1;
  logic [1:0] IDECS;
  logic       IOR;
  logic       IOW;
  logic       DATA_LE;
  logic       ACK;
  logic       TIMEOUT;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 CLKCPU = ~CLKCPU;
  always @(posedge CLKCPU) cyc <= cyc + 1;

  ide_pio_timing dut (
    .CLKCPU (CLKCPU),
    .RESET  (RESET),
    .AS20   (AS20),
    .RW20   (RW20),
    .IDE_SEL(IDE_SEL),
    .A12    (A12),
    .IORDY  (IORDY),
    .IDECS  (IDECS),
    .IOR    (IOR),
    .IOW    (IOW),
    .DATA_LE(DATA_LE),
    .ACK    (ACK),
    .TIMEOUT(TIMEOUT)
  );

  // Per-cycle profile; counts are in clocks, indices relative to the request-sampling edge.
  typedef struct {
    int cs0;
    int cs1;
    int ior;
    int iow;
    int dle;
    int dle_pos;
    int first_cs;
    int first_stb;
    int first_ack;
    int ack_low;
    int timeout;
    int viol;
    int first_cs_abs;
    int last_cs_abs;
    int ack_rise_abs;
    int done;
  } res_t;

  res_t exp_q[$];

  task automatic push_exp(input int cs0, input int cs1, input int ior, input int iow,
                          input int dle, input int dle_pos, input int first_cs,
                          input int first_stb, input int first_ack, input int ack_low,
                          input int timeout);
    res_t e;
    e.cs0 = cs0; e.cs1 = cs1; e.ior = ior; e.iow = iow; e.dle = dle; e.dle_pos = dle_pos;
    e.first_cs = first_cs; e.first_stb = first_stb; e.first_ack = first_ack;
    e.ack_low = ack_low; e.timeout = timeout; e.viol = 0;
    e.first_cs_abs = 0; e.last_cs_abs = 0; e.ack_rise_abs = 0; e.done = 1;
    exp_q.push_back(e);
  endtask

  // Drives one CPU cycle and records what the DUT did. Must be entered just after a negedge.
  // IORDY is pulled low for strobe clocks [lo_start, lo_start+lo_len); abort_clk>0 withdraws
  // AS20 during that strobe clock; flip toggles RW20/A12 mid-cycle.
  task automatic run_cycle(input bit rw, input bit a12, input int lo_start, input int lo_len,
                           input int abort_clk, input bit flip, output res_t o);
    int strobe_n  = 0;
    int abort_idx = 0;
    bit raised    = 1'b0;
    bit aborted   = 1'b0;
    bit stb;
    o = '{default: 0};
    o.first_cs = -1; o.first_stb = -1; o.first_ack = -1;
    o.first_cs_abs = -1; o.ack_rise_abs = -1;
    AS20 = 1'b0; IDE_SEL = 1'b0; RW20 = rw; A12 = a12; IORDY = 1'b1;
    for (int idx = 0; idx < 200; idx++) begin
      @(negedge CLKCPU);
      stb = !IOR || !IOW;
      if (IDECS == 2'b00) o.viol++;
      if (!IOR && !IOW) o.viol++;
      if (stb && IDECS == 2'b11) o.viol++;
      if (!IDECS[0]) o.cs0++;
      if (!IDECS[1]) o.cs1++;
      if (IDECS != 2'b11) begin
        if (o.first_cs < 0) begin o.first_cs = idx; o.first_cs_abs = cyc; end
        o.last_cs_abs = cyc;
      end
      if (!IOR) o.ior++;
      if (!IOW) o.iow++;
      if (stb) begin
        strobe_n++;
        if (o.first_stb < 0) o.first_stb = idx;
      end
      if (DATA_LE) begin o.dle++; o.dle_pos = strobe_n; end
      if (!ACK) begin
        o.ack_low++;
        if (o.first_ack < 0) o.first_ack = idx;
      end
      if (raised && ACK) begin o.ack_rise_abs = cyc; o.done = 1; break; end
      if (aborted && idx >= abort_idx + 20) begin o.done = 1; break; end
      if (flip && idx == 2) begin RW20 = !RW20; A12 = !A12; end
      IORDY = !(stb && strobe_n >= lo_start && strobe_n < lo_start + lo_len);
      if (abort_clk > 0 && !aborted && stb && strobe_n == abort_clk) begin
        AS20 = 1'b1; IDE_SEL = 1'b1; aborted = 1'b1; abort_idx = idx;
      end
      if (!raised && o.ack_low == 2) begin AS20 = 1'b1; IDE_SEL = 1'b1; raised = 1'b1; end
    end
    o.timeout = int'(TIMEOUT);
    IORDY = 1'b1; AS20 = 1'b1; IDE_SEL = 1'b1;
    tests++;
    if (o.done == 0) begin
      fails++;
      $display("FAIL run_cycle: no completion within 200 clk (ack_low=%0d ior=%0d iow=%0d)",
               o.ack_low, o.ior, o.iow);
    end
  endtask

  task automatic idle(input int n);
    AS20 = 1'b1; IDE_SEL = 1'b1; IORDY = 1'b1;
    repeat (n) @(negedge CLKCPU);
  endtask

  task automatic test_reset;
    @(negedge CLKCPU);
    tests++; if (IDECS !== 2'b11) begin fails++; $display("FAIL reset.IDECS got %b want 11", IDECS); end
    tests++; if (IOR !== 1'b1) begin fails++; $display("FAIL reset.IOR got %b want 1", IOR); end
    tests++; if (IOW !== 1'b1) begin fails++; $display("FAIL reset.IOW got %b want 1", IOW); end
    tests++; if (DATA_LE !== 1'b0) begin fails++; $display("FAIL reset.DATA_LE got %b want 0", DATA_LE); end
    tests++; if (ACK !== 1'b1) begin fails++; $display("FAIL reset.ACK got %b want 1", ACK); end
    tests++; if (TIMEOUT !== 1'b0) begin fails++; $display("FAIL reset.TIMEOUT got %b want 0", TIMEOUT); end
    RESET = 1'b0;
    idle(4);
    tests++; if (IDECS !== 2'b11 || ACK !== 1'b1) begin
      fails++; $display("FAIL reset.idle_after_release IDECS=%b ACK=%b want 11/1", IDECS, ACK);
    end
  endtask

  task automatic test_read;
    res_t o, e;
    push_exp(9, 0, 6, 0, 1, 6, 1, 3, 10, 2, 0);
    run_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, o);
    e = exp_q.pop_front();
    tests++; if (o.cs0 !== e.cs0) begin fails++; $display("FAIL read.cs0_low got %0d want %0d", o.cs0, e.cs0); end
    tests++; if (o.cs1 !== e.cs1) begin fails++; $display("FAIL read.cs1_low got %0d want %0d", o.cs1, e.cs1); end
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL read.ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.iow !== e.iow) begin fails++; $display("FAIL read.iow_low got %0d want %0d", o.iow, e.iow); end
    tests++; if (o.dle !== e.dle) begin fails++; $display("FAIL read.data_le_count got %0d want %0d", o.dle, e.dle); end
    tests++; if (o.dle_pos !== e.dle_pos) begin fails++; $display("FAIL read.data_le_pos got %0d want %0d", o.dle_pos, e.dle_pos); end
    tests++; if (o.first_cs !== e.first_cs) begin fails++; $display("FAIL read.cs_edge got %0d want %0d", o.first_cs, e.first_cs); end
    tests++; if (o.first_stb !== e.first_stb) begin fails++; $display("FAIL read.strobe_edge got %0d want %0d", o.first_stb, e.first_stb); end
    tests++; if (o.first_ack !== e.first_ack) begin fails++; $display("FAIL read.ack_edge got %0d want %0d", o.first_ack, e.first_ack); end
    tests++; if (o.ack_low !== e.ack_low) begin fails++; $display("FAIL read.ack_low got %0d want %0d", o.ack_low, e.ack_low); end
    tests++; if (o.viol !== e.viol) begin fails++; $display("FAIL read.overlap_viol got %0d want %0d", o.viol, e.viol); end
    idle(6);
  endtask

  task automatic test_write;
    res_t o, e;
    push_exp(0, 9, 0, 6, 0, 0, 1, 3, 10, 2, 0);
    run_cycle(1'b0, 1'b1, 0, 0, 0, 1'b1, o);
    e = exp_q.pop_front();
    tests++; if (o.cs0 !== e.cs0) begin fails++; $display("FAIL write.cs0_low got %0d want %0d", o.cs0, e.cs0); end
    tests++; if (o.cs1 !== e.cs1) begin fails++; $display("FAIL write.cs1_low got %0d want %0d", o.cs1, e.cs1); end
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL write.ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.iow !== e.iow) begin fails++; $display("FAIL write.iow_low got %0d want %0d", o.iow, e.iow); end
    tests++; if (o.dle !== e.dle) begin fails++; $display("FAIL write.data_le_count got %0d want %0d", o.dle, e.dle); end
    tests++; if (o.first_ack !== e.first_ack) begin fails++; $display("FAIL write.ack_edge got %0d want %0d", o.first_ack, e.first_ack); end
    tests++; if (o.viol !== e.viol) begin fails++; $display("FAIL write.overlap_viol got %0d want %0d", o.viol, e.viol); end
    idle(6);
  endtask

  task automatic test_iordy_wait;
    res_t o, e;
    // 6 active clocks + 3 extra from the low window seen through the synchroniser
    push_exp(12, 0, 9, 0, 1, 9, 1, 3, 13, 2, 0);
    run_cycle(1'b1, 1'b0, 2, 5, 0, 1'b0, o);
    e = exp_q.pop_front();
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL iordy_wait.ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.cs0 !== e.cs0) begin fails++; $display("FAIL iordy_wait.cs0_low got %0d want %0d", o.cs0, e.cs0); end
    tests++; if (o.dle_pos !== e.dle_pos) begin fails++; $display("FAIL iordy_wait.data_le_pos got %0d want %0d", o.dle_pos, e.dle_pos); end
    tests++; if (o.dle !== e.dle) begin fails++; $display("FAIL iordy_wait.data_le_count got %0d want %0d", o.dle, e.dle); end
    tests++; if (o.first_ack !== e.first_ack) begin fails++; $display("FAIL iordy_wait.ack_edge got %0d want %0d", o.first_ack, e.first_ack); end
    tests++; if (o.timeout !== e.timeout) begin fails++; $display("FAIL iordy_wait.timeout got %0d want %0d", o.timeout, e.timeout); end
    idle(6);
  endtask

  task automatic test_iordy_stuck;
    res_t o, e;
    push_exp(24, 0, 21, 0, 1, 21, 1, 3, 25, 2, 1);
    run_cycle(1'b1, 1'b0, 1, 1000, 0, 1'b0, o);
    e = exp_q.pop_front();
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL stuck.ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.cs0 !== e.cs0) begin fails++; $display("FAIL stuck.cs0_low got %0d want %0d", o.cs0, e.cs0); end
    tests++; if (o.dle_pos !== e.dle_pos) begin fails++; $display("FAIL stuck.data_le_pos got %0d want %0d", o.dle_pos, e.dle_pos); end
    tests++; if (o.first_ack !== e.first_ack) begin fails++; $display("FAIL stuck.ack_edge got %0d want %0d", o.first_ack, e.first_ack); end
    tests++; if (o.ack_low !== e.ack_low) begin fails++; $display("FAIL stuck.ack_low got %0d want %0d", o.ack_low, e.ack_low); end
    tests++; if (o.timeout !== e.timeout) begin fails++; $display("FAIL stuck.timeout got %0d want %0d", o.timeout, e.timeout); end
    idle(6);
    tests++; if (TIMEOUT !== 1'b1) begin fails++; $display("FAIL stuck.timeout_sticky got %b want 1", TIMEOUT); end
  endtask

  task automatic test_abort;
    res_t o, e;
    push_exp(6, 0, 3, 0, 0, 0, 1, 3, -1, 0, 0);
    run_cycle(1'b1, 1'b0, 0, 0, 3, 1'b0, o);
    e = exp_q.pop_front();
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL abort.ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.cs0 !== e.cs0) begin fails++; $display("FAIL abort.cs0_low got %0d want %0d", o.cs0, e.cs0); end
    tests++; if (o.dle !== e.dle) begin fails++; $display("FAIL abort.data_le_count got %0d want %0d", o.dle, e.dle); end
    tests++; if (o.ack_low !== e.ack_low) begin fails++; $display("FAIL abort.ack_low got %0d want %0d", o.ack_low, e.ack_low); end
    tests++; if (o.first_ack !== e.first_ack) begin fails++; $display("FAIL abort.ack_edge got %0d want %0d", o.first_ack, e.first_ack); end
    idle(6);
  endtask

  task automatic test_back_to_back;
    res_t o1, o2, e1, e2;
    int cs_gap, rec_gap;
    push_exp(9, 0, 6, 0, 1, 6, 1, 3, 10, 2, 0);
    run_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, o1);
    push_exp(0, 9, 0, 6, 0, 0, -1, -1, -1, 2, 0);
    run_cycle(1'b0, 1'b1, 0, 0, 0, 1'b0, o2);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    cs_gap  = o2.first_cs_abs - o1.last_cs_abs - 1;
    rec_gap = o2.first_cs_abs - o1.ack_rise_abs;
    tests++; if (o1.ior !== e1.ior) begin fails++; $display("FAIL b2b.first_ior_low got %0d want %0d", o1.ior, e1.ior); end
    tests++; if (o1.timeout !== e1.timeout) begin fails++; $display("FAIL b2b.timeout_cleared got %0d want %0d", o1.timeout, e1.timeout); end
    tests++; if (o2.iow !== e2.iow) begin fails++; $display("FAIL b2b.second_iow_low got %0d want %0d", o2.iow, e2.iow); end
    tests++; if (o2.cs1 !== e2.cs1) begin fails++; $display("FAIL b2b.second_cs1_low got %0d want %0d", o2.cs1, e2.cs1); end
    tests++; if (o2.ack_low !== e2.ack_low) begin fails++; $display("FAIL b2b.second_ack_low got %0d want %0d", o2.ack_low, e2.ack_low); end
    tests++; if (cs_gap < 3) begin fails++; $display("FAIL b2b.idecs_idle_gap got %0d want >=3", cs_gap); end
    // three recovery clocks plus at least one clock in IDLE before the next chip select
    tests++; if (rec_gap < 4) begin fails++; $display("FAIL b2b.recover_gap got %0d want >=4", rec_gap); end
    idle(6);
  endtask

  task automatic test_reset_mid_strobe;
    res_t o, e;
    int  n    = 0;
    bit  seen = 1'b0;
    AS20 = 1'b0; IDE_SEL = 1'b0; RW20 = 1'b1; A12 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLKCPU);
      if (!IOR) n++;
      if (n == 2) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL rst_mid.strobe_seen got %0d want 1", seen); end
    RESET = 1'b1;
    #1;
    tests++; if (IOR !== 1'b1) begin fails++; $display("FAIL rst_mid.IOR_async got %b want 1", IOR); end
    tests++; if (IDECS !== 2'b11) begin fails++; $display("FAIL rst_mid.IDECS_async got %b want 11", IDECS); end
    AS20 = 1'b1; IDE_SEL = 1'b1;
    @(negedge CLKCPU);
    RESET = 1'b0;
    idle(4);
    tests++; if (IDECS !== 2'b11 || IOR !== 1'b1 || ACK !== 1'b1) begin
      fails++; $display("FAIL rst_mid.idle_after got IDECS=%b IOR=%b ACK=%b want 11/1/1", IDECS, IOR, ACK);
    end
    push_exp(9, 0, 6, 0, 1, 6, 1, 3, 10, 2, 0);
    run_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, o);
    e = exp_q.pop_front();
    tests++; if (o.ior !== e.ior) begin fails++; $display("FAIL rst_mid.next_ior_low got %0d want %0d", o.ior, e.ior); end
    tests++; if (o.first_cs !== e.first_cs) begin fails++; $display("FAIL rst_mid.next_cs_edge got %0d want %0d", o.first_cs, e.first_cs); end
    tests++; if (o.dle_pos !== e.dle_pos) begin fails++; $display("FAIL rst_mid.next_data_le_pos got %0d want %0d", o.dle_pos, e.dle_pos); end
    idle(4);
  endtask

  initial begin
    repeat (2) @(negedge CLKCPU);
    test_reset();
    test_read();
    test_write();
    test_iordy_wait();
    test_iordy_stuck();
    test_back_to_back();
    test_abort();
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
